mux_scan_n: RTL and testbench

- Parametrised N-channel, W-bit registered selector: the successor to the team's fixed 8:1 32-bit combinational mux.
- Two modes:
  - Manual: an external select chooses the channel.
  - Auto-scan: an internal divider steps through enabled channels at a programmable rate.
- Sits between the data sources (registers, PC, ALU result, memory data) and the display/debug path, which needs time-multiplexed channel viewing.
- Output is registered; every channel change raises a one-cycle strobe.

---
 rtl/mux_scan_n.sv | 138 +++++++++++++
 tb/tb_mux_scan_n.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_n.sv
// mux_scan_n: N-channel, W-bit registered selector for the display/debug path.
// In manual mode an external select picks the channel. In auto-scan mode a
// divider steps through the channels enabled in ch_mask, dwelling period+1
// cycles on each one.
//
// Ports:
//   clk, rst_n   clock; synchronous active-low reset
//   din          packed channel data, channel k at din[k*W +: W]
//   sel          manual channel select
//   mode         0 = manual, 1 = auto-scan
//   ch_mask      auto-scan visit enable per channel
//   period       auto-scan dwell in cycles, minus 1
//   hold         freeze channel and divider; dout still tracks din[cur_ch]
//   dout         registered selected data
//   cur_ch       registered current channel index
//   ch_tick      one-cycle pulse when a new channel's data first appears on dout
//   sel_err      registered; manual select out of range
module mux_scan_n #(
  parameter int unsigned N    = 8,
  parameter int unsigned W    = 32,
  parameter int unsigned SW   = 3,
  parameter int unsigned DIVW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N*W-1:0]  din,
  input  logic [SW-1:0]   sel,
  input  logic            mode,
  input  logic [N-1:0]    ch_mask,
  input  logic [DIVW-1:0] period,
  input  logic            hold,
  output logic [W-1:0]    dout,
  output logic [SW-1:0]   cur_ch,
  output logic            ch_tick,
  output logic            sel_err
);

  // Select space rounded up to a power of two so any SW-bit index is in range.
  localparam int unsigned NP = 1 << SW;

  // Elaboration-time rejection of an undersized select or out-of-range N.
  if ((NP < N) || (N < 2) || (N > 32)) begin : g_param_check
    $error("mux_scan_n: N must be 2..32 and 2**SW must be >= N");
  end

  logic [W-1:0]    ch_data [NP];
  logic [NP-1:0]   mask_p;
  logic [DIVW-1:0] cnt;

  logic [SW-1:0]   adv_ch_c;
  logic [SW-1:0]   idx_c;
  int              pos_c;

  logic [SW-1:0]   cur_nxt_c;
  logic [DIVW-1:0] cnt_nxt_c;
  logic [W-1:0]    dout_nxt_c;
  logic            err_nxt_c;

  // Unpack channels; padding slots beyond N read as zero and are never enabled.
  for (genvar k = 0; k < NP; k++) begin : g_ch
    if (k < N) begin : g_used
      assign ch_data[k] = din[k*W +: W];
      assign mask_p[k]  = ch_mask[k];
    end else begin : g_pad
      assign ch_data[k] = '0;
      assign mask_p[k]  = 1'b0;
    end
  end

  // Circular search for the next enabled channel after cur_ch. Walking the
  // offsets from N down to 1 lets the nearest enabled one win; offset N is
  // cur_ch itself, so a lone enabled current channel stays put and an empty
  // mask leaves cur_ch unchanged.
  always_comb begin
    adv_ch_c = cur_ch;
    idx_c    = '0;
    pos_c    = 0;
    for (int i = int'(N); i > 0; i--) begin
      pos_c = int'(cur_ch) + i;
      if (pos_c >= int'(N)) begin
        pos_c = pos_c - int'(N);
      end
      idx_c = SW'(pos_c);
      if (mask_p[idx_c]) begin
        adv_ch_c = idx_c;
      end
    end
  end

  // Next channel, divider and output data; hold has priority over mode.
  always_comb begin
    cur_nxt_c  = cur_ch;
    cnt_nxt_c  = cnt;
    dout_nxt_c = ch_data[cur_ch];
    err_nxt_c  = sel_err;
    if (hold) begin
      cur_nxt_c = cur_ch;
    end else if (!mode) begin
      cnt_nxt_c = '0;
      if (32'(sel) < N) begin
        cur_nxt_c  = sel;
        dout_nxt_c = ch_data[sel];
        err_nxt_c  = 1'b0;
      end else begin
        dout_nxt_c = '0;
        err_nxt_c  = 1'b1;
      end
    end else begin
      err_nxt_c = 1'b0;
      // >= so that shrinking period below the running count advances at once.
      if (cnt >= period) begin
        cnt_nxt_c = '0;
        cur_nxt_c = adv_ch_c;
      end else begin
        cnt_nxt_c = cnt + DIVW'(1);
      end
      dout_nxt_c = (|ch_mask) ? ch_data[cur_nxt_c] : '0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout    <= '0;
      cur_ch  <= '0;
      cnt     <= '0;
      ch_tick <= 1'b0;
      sel_err <= 1'b0;
    end else begin
      dout    <= dout_nxt_c;
      cur_ch  <= cur_nxt_c;
      cnt     <= cnt_nxt_c;
      ch_tick <= (cur_nxt_c != cur_ch);
      sel_err <= err_nxt_c;
    end
  end

endmodule

// File: tb/tb_mux_scan_n.sv
// tb_mux_scan_n: directed bench for mux_scan_n. An 8-channel instance covers
// sweep, scan, mask, hold, period and reset cases; a 6-channel instance
// sharing the same controls covers out-of-range selects. Each stimulus cycle
// queues its hand-computed expectation; a monitor pops and compares one entry
// per clock, after the edge.
module tb_mux_scan_n;

  localparam int unsigned W    = 32;
  localparam int unsigned N8   = 8;
  localparam int unsigned N6   = 6;
  localparam int unsigned SW   = 3;
  localparam int unsigned DIVW = 16;
  localparam logic [W-1:0] BASE = 32'hA000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [N8*W-1:0] din;
  logic [SW-1:0]   sel;
  logic            mode;
  logic [N8-1:0]   ch_mask;
  logic [DIVW-1:0] period;
  logic            hold;

  logic [W-1:0]  dout8, dout6;
  logic [SW-1:0] ch8, ch6;
  logic          tick8, tick6, err8, err6;

  mux_scan_n #(.N(N8), .W(W), .SW(SW), .DIVW(DIVW)) dut8 (
    .clk(clk), .rst_n(rst_n), .din(din), .sel(sel), .mode(mode),
    .ch_mask(ch_mask), .period(period), .hold(hold),
    .dout(dout8), .cur_ch(ch8), .ch_tick(tick8), .sel_err(err8)
  );

  mux_scan_n #(.N(N6), .W(W), .SW(SW), .DIVW(DIVW)) dut6 (
    .clk(clk), .rst_n(rst_n), .din(din[N6*W-1:0]), .sel(sel), .mode(mode),
    .ch_mask(ch_mask[N6-1:0]), .period(period), .hold(hold),
    .dout(dout6), .cur_ch(ch6), .ch_tick(tick6), .sel_err(err6)
  );

  // Expectation for one clock: d6 picks the 6-channel instance, cd enables the
  // dout check, and a negative xc/xt/xe skips that field.
  typedef struct {
    bit [63:0]    nm;
    bit           d6;
    bit           cd;
    logic [W-1:0] xd;
    int           xc;
    int           xt;
    int           xe;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_bad = 0;
  int   seq[5] = '{0, 2, 5, 7, 0};

  task automatic chk(input bit [63:0] nm, input bit [63:0] fld,
                     input logic [W-1:0] act, input logic [W-1:0] xp);
    n_vec++;
    if (act !== xp) begin
      n_bad++;
      $display("FAIL %0s %0s: got %h expected %h at %0t", nm, fld, act, xp, $time);
    end
  endtask

  // Queue the expectation for the coming edge, then return at the falling edge.
  task automatic cyc(input bit [63:0] nm, input bit d6, input bit cd,
                     input logic [W-1:0] xd, input int xc, input int xt, input int xe);
    exp_t e;
    e.nm = nm; e.d6 = d6; e.cd = cd; e.xd = xd;
    e.xc = xc; e.xt = xt; e.xe = xe;
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Monitor: one expectation per clock, sampled just after the rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        mon_e = q.pop_front();
        if (mon_e.cd)
          chk(mon_e.nm, "dout", mon_e.d6 ? dout6 : dout8, mon_e.xd);
        if (mon_e.xc >= 0)
          chk(mon_e.nm, "cur_ch", W'(mon_e.d6 ? ch6 : ch8), W'(mon_e.xc));
        if (mon_e.xt >= 0)
          chk(mon_e.nm, "ch_tick", W'(mon_e.d6 ? tick6 : tick8), W'(mon_e.xt));
        if (mon_e.xe >= 0)
          chk(mon_e.nm, "sel_err", W'(mon_e.d6 ? err6 : err8), W'(mon_e.xe));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, %0d expectations pending", q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    sel     = '0;
    mode    = 1'b0;
    ch_mask = '0;
    period  = '0;
    hold    = 1'b0;
    for (int k = 0; k < int'(N8); k++) din[k*W +: W] = BASE + W'(k);

    // Reset values on both instances.
    cyc("reset", 1'b0, 1'b1, '0, 0, 0, 0);
    cyc("reset6", 1'b1, 1'b1, '0, 0, 0, 0);
    rst_n = 1'b1;

    // Manual sweep 0..7; channel 0 is no change after reset, so no tick.
    for (int k = 0; k < 8; k++) begin
      sel = SW'(k);
      cyc("sweep", 1'b0, 1'b1, BASE + W'(k), k, (k != 0) ? 1 : 0, 0);
    end

    // Out-of-range selects on the 6-channel instance (which sits at 5 now).
    sel = 3'd3; cyc("oor", 1'b1, 1'b1, BASE + 32'd3, 3, 1, 0);
    sel = 3'd6; cyc("oor", 1'b1, 1'b1, '0, 3, 0, 1);
    sel = 3'd7; cyc("oor", 1'b1, 1'b1, '0, 3, 0, 1);
    sel = 3'd2; cyc("oor", 1'b1, 1'b1, BASE + 32'd2, 2, 1, 0);

    // Auto-scan 0,2,5,7,0 with period 3: advance on every 4th edge.
    sel = 3'd0; cyc("scan", 1'b0, 1'b1, BASE, 0, 1, 0);
    mode = 1'b1; ch_mask = 8'hA5; period = 16'd3;
    for (int i = 1; i <= 16; i++)
      cyc("scan", 1'b0, 1'b1, BASE + W'(seq[i/4]), seq[i/4], (i % 4 == 0) ? 1 : 0, 0);

    // Back to manual: sel lands on the next edge.
    mode = 1'b0; sel = 3'd5;
    cyc("a2m", 1'b0, 1'b1, BASE + 32'd5, 5, 1, 0);

    // Empty mask: channel holds, dout zero, no ticks.
    mode = 1'b1; ch_mask = 8'h00;
    for (int i = 1; i <= 8; i++) cyc("mask0", 1'b0, 1'b1, '0, 5, 0, 0);

    // Only channel 3 enabled: current channel 5 is not enabled but still shown
    // until the first advance; afterwards 3 stays with no further ticks.
    ch_mask = 8'h08;
    for (int i = 1; i <= 12; i++)
      cyc("mask1", 1'b0, 1'b1, BASE + ((i < 4) ? 32'd5 : 32'd3),
          (i < 4) ? 5 : 3, (i == 4) ? 1 : 0, 0);

    // Two edges into a period-5 dwell, then hold for 10 cycles with manual
    // controls applied; din[3] changes while held.
    ch_mask = 8'hA5; period = 16'd5;
    cyc("predwell", 1'b0, 1'b1, BASE + 32'd3, 3, 0, 0);
    cyc("predwell", 1'b0, 1'b1, BASE + 32'd3, 3, 0, 0);
    hold = 1'b1; mode = 1'b0; sel = 3'd1;
    for (int h = 1; h <= 10; h++) begin
      if (h == 6) din[3*W +: W] = 32'hDEAD_0003;
      cyc("hold", 1'b0, 1'b1, (h >= 6) ? 32'hDEAD_0003 : BASE + 32'd3, 3, 0, 0);
    end
    // Count resumes from 2: three more edges, then the advance to 5.
    hold = 1'b0; mode = 1'b1;
    for (int i = 1; i <= 4; i++)
      cyc("unhold", 1'b0, 1'b1, (i < 4) ? 32'hDEAD_0003 : BASE + 32'd5,
          (i < 4) ? 3 : 5, (i == 4) ? 1 : 0, 0);
    din[3*W +: W] = BASE + 32'd3;

    // Period 20 for 9 edges (count reaches 9), then drop to 2.
    period = 16'd20;
    for (int i = 1; i <= 9; i++) cyc("per20", 1'b0, 1'b1, BASE + 32'd5, 5, 0, 0);
    period = 16'd2;
    cyc("per2", 1'b0, 1'b1, BASE + 32'd7, 7, 1, 0);
    cyc("per2", 1'b0, 1'b1, BASE + 32'd7, 7, 0, 0);
    cyc("per2", 1'b0, 1'b1, BASE + 32'd7, 7, 0, 0);
    cyc("per2", 1'b0, 1'b1, BASE, 0, 1, 0);

    // Walk to channel 5 with count 2, then reset for one cycle.
    period = 16'd3;
    for (int i = 1; i <= 10; i++)
      cyc("prerst", 1'b0, 1'b1, BASE + ((i < 4) ? 32'd0 : (i < 8) ? 32'd2 : 32'd5),
          (i < 4) ? 0 : (i < 8) ? 2 : 5, (i == 4 || i == 8) ? 1 : 0, 0);
    rst_n = 1'b0;
    cyc("midrst", 1'b0, 1'b1, '0, 0, 0, 0);
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++)
      cyc("resume", 1'b0, 1'b1, BASE + ((i < 4) ? 32'd0 : 32'd2),
          (i < 4) ? 0 : 2, (i == 4) ? 1 : 0, 0);

    // Every queued expectation must have been consumed.
    @(posedge clk);
    #2;
    chk("drain", "pending", W'(q.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
